// File: rtl/cpu_defs.sv
// Shared CPU definitions: instruction encodings, datapath width and jump FSM states.
package cpu_defs;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } jru_state_e;

endpackage

// File: rtl/jump_target_gen.sv
// Combinational jump target build: pseudo-direct (region from pc4) or register target.
// Only the fields that feed the target are brought in: the 26-bit word field and the pc4 region nibble.
module jump_target_gen
    import cpu_defs::*;
(
    input  logic [25:0]     instr,
    input  logic [3:0]      pc4,
    input  logic [XLEN-1:0] rs_data,
    input  logic            is_jr,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    always_comb begin
        target   = {pc4, instr, 2'b00};
        misalign = 1'b0;
        if (is_jr) begin
            target   = {rs_data[XLEN-1:2], 2'b00};
            misalign = (rs_data[1:0] != 2'b00);
        end
    end

endmodule

// File: rtl/jump_redirect_unit.sv
// ID-stage J/JAL/JR resolver: one registered PC redirect with IF/ID flush and JAL link write.
module jump_redirect_unit
    import cpu_defs::*;
#(
    parameter int unsigned LINK_REG = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc4,
    input  logic [XLEN-1:0] rs_data,
    input  logic            stall,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_ifid,
    output logic            kill_id,
    output logic            link_we,
    output logic [4:0]      link_addr,
    output logic [XLEN-1:0] link_data,
    output logic            addr_err
);

    jru_state_e      state, state_n;
    logic            redirect_n, flush_ifid_n, kill_id_n, link_we_n, addr_err_n;
    logic [XLEN-1:0] redirect_pc_n, link_data_n;

    logic [5:0]      opcode, funct;
    logic            is_j, is_jal, is_jr, is_jump, accept;
    logic [XLEN-1:0] target;
    logic            misalign;

    assign opcode  = id_instr[31:26];
    assign funct   = id_instr[5:0];
    assign is_j    = (opcode == OP_J);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jr   = (opcode == OP_RTYPE) && (funct == FUNCT_JR);
    assign is_jump = is_j || is_jal || is_jr;
    assign accept  = id_valid && !stall && is_jump;

    assign link_addr = 5'(LINK_REG);

    jump_target_gen u_target_gen (
        .instr    (id_instr[25:0]),
        .pc4      (id_pc4[XLEN-1:XLEN-4]),
        .rs_data  (rs_data),
        .is_jr    (is_jr),
        .target   (target),
        .misalign (misalign)
    );

    // State and output registers; a reset abandons any redirect in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            redirect    <= 1'b0;
            flush_ifid  <= 1'b0;
            kill_id     <= 1'b0;
            link_we     <= 1'b0;
            addr_err    <= 1'b0;
            redirect_pc <= '0;
            link_data   <= '0;
        end else begin
            state       <= state_n;
            redirect    <= redirect_n;
            flush_ifid  <= flush_ifid_n;
            kill_id     <= kill_id_n;
            link_we     <= link_we_n;
            addr_err    <= addr_err_n;
            redirect_pc <= redirect_pc_n;
            link_data   <= link_data_n;
        end
    end

    // Next state and next output values; everything holds unless an edge advances it.
    always_comb begin
        state_n       = state;
        redirect_n    = redirect;
        flush_ifid_n  = flush_ifid;
        kill_id_n     = kill_id;
        link_we_n     = link_we;
        addr_err_n    = addr_err;
        redirect_pc_n = redirect_pc;
        link_data_n   = link_data;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n       = ST_REDIRECT;
                    redirect_n    = 1'b1;
                    flush_ifid_n  = 1'b1;
                    kill_id_n     = 1'b1;
                    link_we_n     = is_jal;
                    redirect_pc_n = target;
                    link_data_n   = id_pc4;
                    addr_err_n    = addr_err || misalign;
                end
            end
            ST_REDIRECT: begin
                // ID now holds the wrong-path fetch, so it is never decoded here.
                if (!stall) begin
                    state_n      = ST_IDLE;
                    redirect_n   = 1'b0;
                    flush_ifid_n = 1'b0;
                    kill_id_n    = 1'b0;
                    link_we_n    = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
